// File: rtl/img_boot_pkg.sv
// img_boot_loader shared types: FSM states, sync marker, RGB444 pixel.
// Optional checksum state is used only when IMG_BOOT_CSUM_EN is defined.
package img_boot_pkg;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_HDR  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CSUM = 3'd4,
    S_END  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef logic [11:0] pix_t;

endpackage

// File: rtl/img_boot_if.sv
// UART byte input plus coprocessor boot-load write port.
// master = loader side, slave = UART/coprocessor side.
interface img_boot_if
  import img_boot_pkg::*;
#(
  parameter int ADDR_W = 17
);
  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic          we_boot;
  logic [ADDR_W:0] waddr_boot;
  pix_t          wdata_boot;
  logic          bootloading;
  logic          boot_done;
  logic          boot_err;

  modport master (
    input  rx_data, rx_rdy,
    output we_boot, waddr_boot, wdata_boot,
    output bootloading, boot_done, boot_err
  );

  modport slave (
    output rx_data, rx_rdy,
    input  we_boot, waddr_boot, wdata_boot,
    input  bootloading, boot_done, boot_err
  );
endinterface

// File: rtl/img_boot_timeout.sv
// Inter-byte watchdog: reloads on every byte, counts down while a
// frame is open and flags expiry unless a byte lands that cycle.
module img_boot_timeout #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic act,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (act) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && !act && cnt == '0;

endmodule

// File: rtl/img_boot_loader.sv
// UART frame parser feeding the image coprocessor boot-load port.
// Define IMG_BOOT_CSUM_EN to require a trailing mod-256 checksum byte.
module img_boot_loader
  import img_boot_pkg::*;
#(
  parameter int         NUM_PIX   = 76800,
  parameter int         ADDR_W    = 17,
  parameter int         TIMEOUT   = 1_000_000,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input logic      clk,
  input logic      rst_n,
  img_boot_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_PIX - 1);

  state_t            state;
  logic              img_sel;
  logic [ADDR_W-1:0] pix_idx;
  logic [3:0]        r_q;
  logic              we_q;
  logic [ADDR_W:0]   waddr_q;
  pix_t              wdata_q;
  logic              bl_q;
  logic              done_q;
  logic              err_q;
  logic              run;
  logic              expire;
  logic              rdy;
  logic [7:0]        rxd;
`ifdef IMG_BOOT_CSUM_EN
  logic [7:0]        sum_q;
`endif

  assign rdy = bus.rx_rdy;
  assign rxd = bus.rx_data;
  assign run = state inside {S_HDR, S_HI, S_LO, S_CSUM};

  img_boot_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_to (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .act   (rdy),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_SYNC;
      img_sel <= 1'b0;
      pix_idx <= '0;
      r_q     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      bl_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMG_BOOT_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (expire) begin
        err_q <= 1'b1;
        bl_q  <= 1'b0;
        state <= S_SYNC;
      end else begin
        unique case (state)
          S_SYNC: begin
            if (rdy && rxd == SYNC_BYTE)
              state <= S_HDR;
          end
          S_HDR: begin
            if (rdy) begin
              if (rxd[7:1] == 7'd0) begin
                img_sel <= rxd[0];
                pix_idx <= '0;
                bl_q    <= 1'b1;
                state   <= S_HI;
`ifdef IMG_BOOT_CSUM_EN
                sum_q   <= '0;
`endif
              end else begin
                err_q <= 1'b1;
                state <= S_SYNC;
              end
            end
          end
          S_HI: begin
            if (rdy) begin
              r_q   <= rxd[3:0];
              state <= S_LO;
`ifdef IMG_BOOT_CSUM_EN
              sum_q <= sum_q + rxd;
`endif
            end
          end
          S_LO: begin
            if (rdy) begin
              we_q    <= 1'b1;
              wdata_q <= {r_q, rxd};
              waddr_q <= {img_sel, pix_idx};
`ifdef IMG_BOOT_CSUM_EN
              sum_q   <= sum_q + rxd;
`endif
              if (pix_idx == LAST) begin
`ifdef IMG_BOOT_CSUM_EN
                state <= S_CSUM;
`else
                state <= S_END;
`endif
              end else begin
                pix_idx <= pix_idx + 1'b1;
                state   <= S_HI;
              end
            end
          end
          S_CSUM: begin
`ifdef IMG_BOOT_CSUM_EN
            if (rdy) begin
              if (rxd == sum_q) begin
                state <= S_END;
              end else begin
                err_q <= 1'b1;
                bl_q  <= 1'b0;
                state <= S_SYNC;
              end
            end
`else
            state <= S_SYNC;
`endif
          end
          S_END: begin
            bl_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= S_SYNC;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

  assign bus.we_boot     = we_q;
  assign bus.waddr_boot  = waddr_q;
  assign bus.wdata_boot  = wdata_q;
  assign bus.bootloading = bl_q;
  assign bus.boot_done   = done_q;
  assign bus.boot_err    = err_q;

endmodule

// File: tb/tb_img_boot_loader.sv
// Scoreboard bench for img_boot_loader with a small slot and short
// timeout; also covers the IMG_BOOT_CSUM_EN build.
module tb_img_boot_loader;
  import img_boot_pkg::*;

  localparam int NP = 12;
  localparam int AW = 17;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  img_boot_if #(.ADDR_W(AW)) bus();

  img_boot_loader #(
    .NUM_PIX  (NP),
    .ADDR_W   (AW),
    .TIMEOUT  (TO),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  typedef struct packed {
    logic [AW:0] a;
    pix_t        d;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] evq[$];
  wr_t        w;
  int vecs = 0;
  int miss = 0;
  int nwr = 0;
  int npush = 0;
  int nev = 0;
  int nevp = 0;
  int n0;
  logic [7:0] sum;
  logic [7:0] h, l;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.we_boot) begin
      nwr++;
      if (wq.size() == 0) begin
        check("wr_extra", nwr, npush);
      end else begin
        w = wq.pop_front();
        check("waddr", 32'(bus.waddr_boot), 32'(w.a));
        check("wdata", 32'(bus.wdata_boot), 32'(w.d));
      end
    end
    if (bus.boot_done || bus.boot_err) begin
      nev++;
      if (evq.size() == 0)
        check("ev_extra", nev, nevp);
      else
        check("event", {bus.boot_done, bus.boot_err},
              evq.pop_front());
      if (bus.boot_done)
        check("bl_at_done", bus.bootloading, 0);
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input logic [1:0] e);
    evq.push_back(e);
    nevp++;
  endtask

  task automatic push_wr(input logic sel, input int idx,
                         input logic [7:0] hi,
                         input logic [7:0] lo);
    wr_t x;
    x.a = {sel, AW'(idx)};
    x.d = {hi[3:0], lo};
    wq.push_back(x);
    npush++;
  endtask

  task automatic hdr(input logic [7:0] hb);
    send(8'hA5);
    send(hb);
    sum = 8'd0;
  endtask

  task automatic pix(input logic sel, input int idx,
                     input logic [7:0] hi,
                     input logic [7:0] lo);
    push_wr(sel, idx, hi, lo);
    send(hi);
    send(lo);
    sum = sum + hi + lo;
  endtask

  task automatic rnd_pix(input logic sel, input int idx);
    h = 8'($urandom);
    l = 8'($urandom);
    pix(sel, idx, h, l);
  endtask

  task automatic tail(input bit good);
`ifdef IMG_BOOT_CSUM_EN
    push_ev(good ? 2'b10 : 2'b01);
    send(good ? sum : sum + 8'd1);
`else
    push_ev({good, ~good});
`endif
    idle(4);
    check("wr_left", wq.size(), 0);
    check("ev_left", evq.size(), 0);
    check("bl_idle", bus.bootloading, 0);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_we"}, bus.we_boot, 0);
    check({tag, "_wa"}, 32'(bus.waddr_boot), 0);
    check({tag, "_wd"}, 32'(bus.wdata_boot), 0);
    check({tag, "_bl"}, bus.bootloading, 0);
    check({tag, "_dn"}, bus.boot_done, 0);
    check({tag, "_er"}, bus.boot_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.rx_data = 8'd0;
    bus.rx_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;

    // full frame, fixed pattern, slot 0
    hdr(8'h00);
    check("bl_open", bus.bootloading, 1);
    for (int i = 0; i < NP; i++) pix(1'b0, i, 8'h0F, 8'h3C);
    tail(1'b1);
    check("nwr_a", nwr, NP);

    // slot 1, upper nibble of hi byte dropped
    hdr(8'h01);
    pix(1'b1, 0, 8'hF5, 8'hA7);
    for (int i = 1; i < NP; i++) rnd_pix(1'b1, i);
    tail(1'b1);

`ifdef IMG_BOOT_CSUM_EN
    // bad checksum still writes every pixel
    n0 = nwr;
    hdr(8'h00);
    for (int i = 0; i < NP; i++) rnd_pix(1'b0, i);
    tail(1'b0);
    check("nwr_badcs", nwr - n0, NP);
`endif

    // bad header
    n0 = nwr;
    push_ev(2'b01);
    hdr(8'h02);
    check("bl_badhdr", bus.bootloading, 0);
    send(8'h12);
    send(8'h34);
    idle(3);
    check("nwr_badhdr", nwr - n0, 0);
    check("ev_badhdr", evq.size(), 0);
    hdr(8'h00);
    for (int i = 0; i < NP; i++) rnd_pix(1'b0, i);
    tail(1'b1);

    // stall after 10 pixels
    n0 = nwr;
    hdr(8'h00);
    for (int i = 0; i < 10; i++) rnd_pix(1'b0, i);
    idle(TO - 1);
    check("bl_pre_to", bus.bootloading, 1);
    push_ev(2'b01);
    idle(1);
    check("bl_to", bus.bootloading, 0);
    idle(3);
    check("nwr_to", nwr - n0, 10);
    check("ev_to", evq.size(), 0);

    // byte landing on the expiry cycle keeps the frame
    hdr(8'h01);
    rnd_pix(1'b1, 0);
    h = 8'($urandom);
    l = 8'($urandom);
    push_wr(1'b1, 1, h, l);
    send(h);
    idle(TO - 1);
    send(l);
    sum = sum + h + l;
    check("bl_edge", bus.bootloading, 1);
    for (int i = 2; i < NP; i++) rnd_pix(1'b1, i);
    tail(1'b1);

    // reset mid-frame
    n0 = nwr;
    hdr(8'h00);
    for (int i = 0; i < 3; i++) rnd_pix(1'b0, i);
    send(8'h77);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("mid_rst");
    rst_n = 1'b1;
    send(8'h3C);
    send(8'h00);
    send(8'h11);
    idle(3);
    check("nwr_rst", nwr - n0, 3);
    hdr(8'h01);
    for (int i = 0; i < NP; i++) rnd_pix(1'b1, i);
    tail(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
